// File: rtl/imem_loader.sv
// Boot loader: streams instruction words into imem at consecutive
// word addresses, then releases the core reset so it starts at PC 0.
module imem_loader #(
    parameter int DEPTH       = 256,
    parameter int ADDR_W      = 8,
    parameter int HOLD_CYCLES = 4
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W:0]   load_len,
    input  logic [31:0]       in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic              imem_we,
    output logic [31:0]       imem_addr,
    output logic [31:0]       imem_wdata,
    output logic              cpu_reset,
    output logic              busy,
    output logic              done,
    output logic              error,
    output logic [31:0]       checksum
);
    localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W+1)'(DEPTH);
    localparam logic [7:0]      HOLD_LAST = 8'(HOLD_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, LOAD, HOLD, RUN} state_t;

    state_t            state;
    state_t            state_nx;
    logic [ADDR_W:0]   len;
    logic [ADDR_W:0]   count;
    logic [7:0]        hold_cnt;
    logic [ADDR_W-1:0] wr_idx;
    logic              accept;
    logic              can_start;
    logic              len_ok;
    logic              last_word;
    logic              hold_end;

    assign accept    = in_valid && in_ready;
    assign can_start = start && (state == IDLE || state == RUN);
    assign len_ok    = (load_len != '0) && (load_len <= DEPTH_L);
    assign last_word = (count + 1'b1) == len;
    assign hold_end  = hold_cnt == HOLD_LAST;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE, RUN: if (can_start && len_ok) state_nx = LOAD;
            LOAD:      if (accept && last_word) state_nx = HOLD;
            HOLD:      if (hold_end) state_nx = RUN;
            default:   state_nx = IDLE;
        endcase
    end

    always_comb begin
        in_ready  = 1'b0;
        cpu_reset = 1'b1;
        busy      = 1'b0;
        done      = 1'b0;
        unique case (state)
            LOAD: begin
                in_ready = 1'b1;
                busy     = 1'b1;
            end
            HOLD: busy = 1'b1;
            RUN: begin
                cpu_reset = 1'b0;
                done      = 1'b1;
            end
            default: ;
        endcase
    end

    // Write port is registered: the word accepted on one edge is
    // presented to imem during the following cycle.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            len        <= '0;
            count      <= '0;
            hold_cnt   <= '0;
            wr_idx     <= '0;
            imem_we    <= 1'b0;
            imem_wdata <= '0;
            checksum   <= '0;
            error      <= 1'b0;
        end else begin
            imem_we <= accept;
            if (accept) begin
                wr_idx     <= count[ADDR_W-1:0];
                imem_wdata <= in_data;
                count      <= count + 1'b1;
                checksum   <= checksum ^ in_data;
            end
            if (can_start) begin
                if (len_ok) begin
                    len      <= load_len;
                    count    <= '0;
                    checksum <= '0;
                    error    <= 1'b0;
                end else begin
                    error <= 1'b1;
                end
            end
            if (state == HOLD) begin
                hold_cnt <= hold_cnt + 1'b1;
            end else begin
                hold_cnt <= '0;
            end
        end
    end

    assign imem_addr = {{(30-ADDR_W){1'b0}}, wr_idx, 2'b00};

endmodule

// File: tb/tb_imem_loader.sv
// Scoreboard bench for imem_loader: the stimulus side predicts each
// write, an independent monitor checks what the write port shows.
module tb_imem_loader;
    localparam int DEPTH = 256;
    localparam int ADDR_W = 8;
    localparam int HOLD = 4;

    logic              clock = 1'b0;
    logic              reset;
    logic              start = 1'b0;
    logic [ADDR_W:0]   load_len = '0;
    logic [31:0]       in_data = '0;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic              imem_we;
    logic [31:0]       imem_addr;
    logic [31:0]       imem_wdata;
    logic              cpu_reset;
    logic              busy;
    logic              done;
    logic              error;
    logic [31:0]       checksum;

    imem_loader #(
        .DEPTH(DEPTH),
        .ADDR_W(ADDR_W),
        .HOLD_CYCLES(HOLD)
    ) dut (
        .clock(clock),
        .reset(reset),
        .start(start),
        .load_len(load_len),
        .in_data(in_data),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .imem_we(imem_we),
        .imem_addr(imem_addr),
        .imem_wdata(imem_wdata),
        .cpu_reset(cpu_reset),
        .busy(busy),
        .done(done),
        .error(error),
        .checksum(checksum)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
        int          cyc;
    } wr_t;

    wr_t         q[$];
    logic [31:0] src[$];
    int          cyc = 0;
    int          total = 0;
    int          bad = 0;

    always @(posedge clock) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Monitor: every write must match the oldest predicted write.
    always @(negedge clock) begin
        if (reset && imem_we) begin
            if (q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_write actual=%h/%h required=none",
                         imem_addr, imem_wdata);
            end else begin
                wr_t e;
                e = q.pop_front();
                chk("wr_addr", imem_addr, e.addr);
                chk("wr_data", imem_wdata, e.data);
                chk("wr_cycle", cyc, e.cyc);
            end
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic pulse_start(input int n);
        start = 1'b1;
        load_len = (ADDR_W+1)'(n);
        tick();
        start = 1'b0;
    endtask

    task automatic push_exp(input int idx, input logic [31:0] d);
        wr_t e;
        e.addr = 32'(idx * 4);
        e.data = d;
        e.cyc  = cyc + 1;
        q.push_back(e);
    endtask

    task automatic do_reset();
        reset = 1'b0;
        repeat (2) tick();
        q.delete();
        reset = 1'b1;
        tick();
    endtask

    // mode 0: continuous valid, 1: alternating 1,0,1,..., 2: random gaps
    task automatic run_load(input int n, input int mode);
        int          idx = 0;
        int          budget = 0;
        int          hc = 0;
        logic [31:0] ck = '0;
        pulse_start(n);
        while (idx < n && budget < 4 * n + 20) begin
            case (mode)
                0:       in_valid = 1'b1;
                1:       in_valid = (budget % 2) == 0;
                default: in_valid = $urandom_range(0, 2) != 0;
            endcase
            in_data = (idx < src.size()) ? src[idx] : $urandom;
            @(negedge clock);
            chk("in_ready_load", in_ready, 1'b1);
            chk("cpu_reset_load", cpu_reset, 1'b1);
            if (in_valid) begin
                push_exp(idx, in_data);
                ck ^= in_data;
                idx++;
            end
            budget++;
            tick();
        end
        in_valid = 1'b0;
        if (idx != n) chk("load_timeout", idx, n);
        for (int k = 0; k < 40; k++) begin
            @(negedge clock);
            if (k == 0) chk("in_ready_hold", in_ready, 1'b0);
            if (!cpu_reset) break;
            hc++;
        end
        chk("hold_cycles", hc, HOLD);
        chk("checksum", checksum, ck);
        chk("done", done, 1'b1);
        chk("busy_run", busy, 1'b0);
        chk("in_ready_run", in_ready, 1'b0);
        chk("error_clear", error, 1'b0);
        tick();
    endtask

    task automatic bad_start(input int n, input logic in_run);
        pulse_start(n);
        @(negedge clock);
        chk("bad_error", error, 1'b1);
        chk("bad_in_ready", in_ready, 1'b0);
        chk("bad_busy", busy, 1'b0);
        chk("bad_done", done, in_run);
        chk("bad_cpu_reset", cpu_reset, !in_run);
        tick();
    endtask

    initial begin
        reset = 1'b1;
        #1 reset = 1'b0;
        #1;
        chk("rst_cpu_reset", cpu_reset, 1'b1);
        chk("rst_in_ready", in_ready, 1'b0);
        chk("rst_we", imem_we, 1'b0);
        chk("rst_addr", imem_addr, 32'h0);
        chk("rst_wdata", imem_wdata, 32'h0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_error", error, 1'b0);
        chk("rst_checksum", checksum, 32'h0);
        repeat (2) tick();
        reset = 1'b1;
        tick();

        src = '{32'h20080005, 32'h20090007, 32'h01095020};
        run_load(3, 0);
        run_load(3, 1);

        do_reset();
        in_valid = 1'b1;
        in_data = 32'hdeadbeef;
        bad_start(0, 1'b0);
        bad_start(DEPTH + 1, 1'b0);
        repeat (2) tick();
        in_valid = 1'b0;

        src.delete();
        run_load(DEPTH, 0);

        bad_start(0, 1'b1);

        src = '{$urandom};
        run_load(1, 0);

        for (int i = 0; i < 4; i++) begin
            src.delete();
            run_load($urandom_range(1, 20), 2);
        end

        do_reset();
        src.delete();
        pulse_start(5);
        for (int i = 0; i < 2; i++) begin
            in_valid = 1'b1;
            in_data = $urandom;
            @(negedge clock);
            push_exp(i, in_data);
            tick();
        end
        chk("we_before_reset", imem_we, 1'b1);
        #2 reset = 1'b0;
        #1;
        q.delete();
        chk("mid_cpu_reset", cpu_reset, 1'b1);
        chk("mid_in_ready", in_ready, 1'b0);
        chk("mid_we", imem_we, 1'b0);
        chk("mid_addr", imem_addr, 32'h0);
        chk("mid_wdata", imem_wdata, 32'h0);
        chk("mid_busy", busy, 1'b0);
        chk("mid_checksum", checksum, 32'h0);
        repeat (3) tick();
        reset = 1'b1;
        repeat (3) tick();
        chk("post_busy", busy, 1'b0);
        chk("post_in_ready", in_ready, 1'b0);
        chk("post_cpu_reset", cpu_reset, 1'b1);
        in_valid = 1'b0;
        repeat (2) tick();

        chk("queue_drained", q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
